// File: rtl/dds_pkg.sv
// Shared defaults and helpers for the DDS phase accumulator.
// DDS_GLIDE_EN enables portamento in dds_phase_acc.
package dds_pkg;
   localparam int ACC_W_DEF       = 24;
   localparam int N_DEF           = 14;
   localparam int TUNE_W_DEF      = 16;
   localparam int DIV_DEF         = 256;
   localparam int GLIDE_SHIFT_DEF = 6;

   // Lowest accumulator bit that lands in the phase output.
   function automatic int phase_lsb(input int acc_w, input int n_w);
      return acc_w - n_w;
   endfunction
endpackage

// File: rtl/dds_tick_gen.sv
// Sample-rate divider: registered one-cycle tick after count reaches DIV-1.
module dds_tick_gen import dds_pkg::*; #(
   parameter int DIV = DIV_DEF
) (
   input  logic clk,
   input  logic rst,
   output logic tick
);
   localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [CW-1:0] LAST = CW'(DIV - 1);

   logic [CW-1:0] count;

   always_ff @(posedge clk) begin
      if (rst) begin
         count <= '0;
         tick  <= 1'b0;
      end else begin
         tick  <= (count == LAST);
         count <= (count == LAST) ? '0 : count + CW'(1);
      end
   end
endmodule

// File: rtl/dds_phase_acc.sv
// DDS phase accumulator with tuning-word handshake, hard sync and wrap pulse.
// Define DDS_GLIDE_EN to slew inc toward the accepted word (portamento).
module dds_phase_acc import dds_pkg::*; #(
   parameter int ACC_W  = ACC_W_DEF,
   parameter int n      = N_DEF,
   parameter int TUNE_W = TUNE_W_DEF,
   parameter int DIV    = DIV_DEF
`ifdef DDS_GLIDE_EN
   , parameter int GLIDE_SHIFT = GLIDE_SHIFT_DEF
`endif
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              en,
   input  logic [TUNE_W-1:0] tune,
   input  logic              tune_valid,
   output logic              tune_ready,
   input  logic              sync,
   output logic [n-1:0]      phase,
   output logic              wrap,
   output logic              tick
);
   localparam int PH_LO = phase_lsb(ACC_W, n);

   logic [ACC_W-1:0]  acc;
   logic [TUNE_W-1:0] inc;
   logic [TUNE_W-1:0] pend_word;
   logic              pend;
   logic [ACC_W:0]    sum;
   logic              accept;

   dds_tick_gen #(.DIV(DIV)) u_tick (.clk(clk), .rst(rst), .tick(tick));

   assign tune_ready = !pend;
   assign accept     = tune_valid && tune_ready;
   assign phase      = acc[ACC_W-1:PH_LO];
   // Extra top bit captures the carry that becomes the wrap pulse.
   assign sum        = {1'b0, acc} + {{(ACC_W + 1 - TUNE_W){1'b0}}, inc};

   always_ff @(posedge clk) begin
      if (rst) begin
         pend      <= 1'b0;
         pend_word <= '0;
      end else if (tick && pend) begin
         pend <= 1'b0;
      end else if (accept) begin
         pend      <= 1'b1;
         pend_word <= tune;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         acc  <= '0;
         wrap <= 1'b0;
      end else begin
         wrap <= 1'b0;
         if (sync) begin
            acc <= '0;
         end else if (tick && en) begin
            acc  <= sum[ACC_W-1:0];
            wrap <= sum[ACC_W];
         end
      end
   end

`ifdef DDS_GLIDE_EN
   logic [TUNE_W-1:0] target;
   logic [TUNE_W-1:0] diff;
   logic [TUNE_W-1:0] step;
   logic [TUNE_W-1:0] inc_next;

   // step never exceeds diff, so inc lands on target without overshoot.
   always_comb begin
      diff     = (target > inc) ? target - inc : inc - target;
      step     = diff >> GLIDE_SHIFT;
      inc_next = inc;
      if (step == '0) step = TUNE_W'(1);
      if (target > inc)      inc_next = inc + step;
      else if (target < inc) inc_next = inc - step;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         target <= '0;
         inc    <= '0;
      end else if (tick) begin
         inc <= inc_next;
         if (pend) target <= pend_word;
      end
   end
`else
   always_ff @(posedge clk) begin
      if (rst)              inc <= '0;
      else if (tick && pend) inc <= pend_word;
   end
`endif
endmodule

// File: tb/tb_dds_phase_acc.sv
// Bench for dds_phase_acc: DIV=1 and DIV=4 instances against a cycle-level reference model.
module tb_dds_phase_acc;
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst;
   logic        en1, sync1, tv1, rdy1, wrap1, tick1;
   logic        en4, sync4, tv4, rdy4, wrap4, tick4;
   logic [15:0] tune1, tune4;
   logic [13:0] phase1, phase4;
   int tests = 0;
   int fails = 0;

   dds_phase_acc #(.ACC_W(24), .n(14), .TUNE_W(16), .DIV(1)) u_d1 (
      .clk(clk), .rst(rst), .en(en1), .tune(tune1), .tune_valid(tv1), .tune_ready(rdy1),
      .sync(sync1), .phase(phase1), .wrap(wrap1), .tick(tick1));

   dds_phase_acc #(.ACC_W(24), .n(14), .TUNE_W(16), .DIV(4)) u_d4 (
      .clk(clk), .rst(rst), .en(en4), .tune(tune4), .tune_valid(tv4), .tune_ready(rdy4),
      .sync(sync4), .phase(phase4), .wrap(wrap4), .tick(tick4));

   // Reference state: k counts clock edges since reset; a tick follows every DIV-th edge.
   typedef struct {
      longint acc; longint inc; longint tgt; longint pw; longint k;
      bit pend; bit tick; bit wrap;
   } mdl_t;

   mdl_t m1, m4;

   function automatic mdl_t mstep(mdl_t m, int div, logic r, logic e, logic s, logic v,
                                  logic [15:0] t);
      mdl_t x;
      longint total, d, st;
      x = m;
      if (r) begin
         x = '{default: 0};
         return x;
      end
      x.k    = m.k + 1;
      x.tick = (x.k % div) == 0;
      x.wrap = 0;
      if (s) x.acc = 0;
      else if (m.tick && e) begin
         total  = m.acc + m.inc;
         x.wrap = total >= 64'd16777216;
         x.acc  = total % 64'd16777216;
      end
      if (m.tick) begin
`ifdef DDS_GLIDE_EN
         if (m.inc != m.tgt) begin
            d  = (m.tgt > m.inc) ? m.tgt - m.inc : m.inc - m.tgt;
            st = d / 64;
            if (st == 0) st = 1;
            x.inc = (m.tgt > m.inc) ? m.inc + st : m.inc - st;
         end
         if (m.pend) x.tgt = m.pw;
`else
         if (m.pend) x.inc = m.pw;
`endif
         x.pend = 0;
      end
      if (!m.pend && v) begin
         x.pend = 1;
         x.pw   = t;
      end
      return x;
   endfunction

   always @(posedge clk) begin
      m1 = mstep(m1, 1, rst, en1, sync1, tv1, tune1);
      m4 = mstep(m4, 4, rst, en4, sync4, tv4, tune4);
   end

   task automatic cyc();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      en1 = 0; sync1 = 0; tv1 = 0; en4 = 0; sync4 = 0; tv4 = 0;
      cyc(); cyc();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1; en1 = 1; en4 = 1; tv1 = 1; tv4 = 1; sync1 = 0; sync4 = 0;
      tune1 = 16'h4000; tune4 = 16'h4000;
      cyc(); cyc();
      tests++;
      if ({phase1, wrap1, tick1, rdy1} !== {14'd0, 1'b0, 1'b0, 1'b1}) begin
         fails++;
         $display("FAIL reset_d1: phase=%h wrap=%b tick=%b ready=%b, want 0 0 0 1",
                  phase1, wrap1, tick1, rdy1);
      end
      tests++;
      if ({phase4, wrap4, tick4, rdy4} !== {14'd0, 1'b0, 1'b0, 1'b1}) begin
         fails++;
         $display("FAIL reset_d4: phase=%h wrap=%b tick=%b ready=%b, want 0 0 0 1",
                  phase4, wrap4, tick4, rdy4);
      end
      rst = 1'b0; tv1 = 0; tv4 = 0;
      for (int i = 0; i < 16; i++) begin
         cyc();
         tests++;
         if (phase1 !== 14'd0 || wrap1 !== 1'b0 || rdy1 !== 1'b1 || tick1 !== 1'b1) begin
            fails++;
            $display("FAIL post_reset_d1 cyc %0d: phase=%h wrap=%b ready=%b tick=%b, want 0 0 1 1",
                     i, phase1, wrap1, rdy1, tick1);
         end
         tests++;
         if (phase4 !== 14'd0 || tick4 !== (((i + 1) % 4) == 0)) begin
            fails++;
            $display("FAIL post_reset_d4 cyc %0d: phase=%h tick=%b, want 0 %b",
                     i, phase4, tick4, ((i + 1) % 4) == 0);
         end
      end
   endtask

   task automatic test_tune_step();
      logic [13:0] prev;
      int wraps = 0, first_w = 0, second_w = 0;
      do_reset();
      en1 = 1; tune1 = 16'h4000; tv1 = 1;
      cyc();
      tv1 = 0;
      tests++;
      if (rdy1 !== 1'b0) begin
         fails++; $display("FAIL ready_low: ready=%b, want 0", rdy1);
      end
      cyc();
      tests++;
      if (rdy1 !== 1'b1 || phase1 !== 14'd0) begin
         fails++; $display("FAIL ready_back: ready=%b phase=%h, want 1 0", rdy1, phase1);
      end
      for (int i = 0; i < 2100; i++) begin
         prev = phase1;
         cyc();
         tests++;
         if (phase1 !== 14'(prev + 14'd16)) begin
            fails++; $display("FAIL step16 cyc %0d: phase=%h, want %h", i, phase1, 14'(prev + 14'd16));
         end
         if (wrap1 === 1'b1) begin
            wraps++;
            if (wraps == 1) first_w = i;
            if (wraps == 2) second_w = i;
            tests++;
            if (phase1 !== 14'd0) begin
               fails++; $display("FAIL wrap_phase: phase=%h at wrap, want 0", phase1);
            end
         end
      end
      tests++;
      if (wraps !== 2) begin
         fails++; $display("FAIL wrap_count: got %0d wraps, want 2", wraps);
      end
      tests++;
      if (second_w - first_w !== 1024) begin
         fails++; $display("FAIL wrap_period: got %0d ticks, want 1024", second_w - first_w);
      end
   endtask

   task automatic test_div4();
      logic [13:0] prev;
      logic        prev_tick;
      int          gap = 0;
      do_reset();
      en4 = 1; tune4 = 16'h0400; tv4 = 1;
      cyc();
      tv4 = 0;
      for (int i = 0; i < 12; i++) begin
         cyc();
         tests++;
         if (phase4 !== 14'(m4.acc >> 10)) begin
            fails++; $display("FAIL div4_warm cyc %0d: phase=%h, want %h", i, phase4, 14'(m4.acc >> 10));
         end
      end
      for (int i = 0; i < 40; i++) begin
         prev = phase4; prev_tick = tick4;
         cyc();
         gap++;
         tests++;
         if (phase4 !== (prev_tick ? 14'(prev + 14'd1) : prev)) begin
            fails++;
            $display("FAIL div4_step cyc %0d: phase=%h, want %h", i, phase4,
                     prev_tick ? 14'(prev + 14'd1) : prev);
         end
         if (tick4 === 1'b1) begin
            tests++;
            if (gap !== 4 && i >= 4) begin
               fails++; $display("FAIL div4_tick_gap: gap=%0d, want 4", gap);
            end
            gap = 0;
         end
      end
   endtask

   task automatic test_sync();
      int guard = 0;
      do_reset();
      en1 = 1; tune1 = 16'h4000; tv1 = 1;
      cyc();
      tv1 = 0;
      while (phase1 !== 14'h2000 && guard < 2000) begin
         cyc(); guard++;
      end
      tests++;
      if (phase1 !== 14'h2000) begin
         fails++; $display("FAIL sync_reach: phase=%h, want 2000 (timeout)", phase1);
      end
      sync1 = 1;
      cyc();
      sync1 = 0;
      tests++;
      if (phase1 !== 14'd0 || wrap1 !== 1'b0) begin
         fails++; $display("FAIL sync_clear: phase=%h wrap=%b, want 0 0", phase1, wrap1);
      end
      cyc();
      tests++;
      if (phase1 !== 14'd16 || wrap1 !== 1'b0) begin
         fails++; $display("FAIL sync_resume1: phase=%h wrap=%b, want 0010 0", phase1, wrap1);
      end
      cyc();
      tests++;
      if (phase1 !== 14'd32) begin
         fails++; $display("FAIL sync_resume2: phase=%h, want 0020", phase1);
      end
   endtask

   task automatic test_en_gate();
      logic [13:0] p;
      do_reset();
      en1 = 1; tune1 = 16'h4000; tv1 = 1;
      cyc();
      tv1 = 0;
      repeat (50) cyc();
      en1 = 0; tune1 = 16'h8000; tv1 = 1; p = phase1;
      cyc();
      tv1 = 0;
      for (int i = 0; i < 10; i++) begin
         tests++;
         if (phase1 !== p || wrap1 !== 1'b0) begin
            fails++; $display("FAIL en_hold cyc %0d: phase=%h wrap=%b, want %h 0", i, phase1, wrap1, p);
         end
         cyc();
      end
      en1 = 1;
      cyc();
      tests++;
      if (phase1 !== 14'(p + 14'd32)) begin
         fails++; $display("FAIL en_resume: phase=%h, want %h", phase1, 14'(p + 14'd32));
      end
   endtask

`ifdef DDS_GLIDE_EN
   task automatic test_glide();
      logic [15:0] pi, cur;
      bit          first = 1;
      int          guard = 0;
      do_reset();
      en1 = 1; tune1 = 16'h1000; tv1 = 1;
      cyc();
      tv1 = 0;
      pi = u_d1.inc;
      while (u_d1.inc !== 16'h1000 && guard < 2000) begin
         cyc(); guard++;
         cur = u_d1.inc;
         if (cur !== pi && first) begin
            first = 0;
            tests++;
            if (cur - pi !== 16'd64) begin
               fails++; $display("FAIL glide_first: step=%0d, want 64", cur - pi);
            end
         end
         tests++;
         if (cur < pi || cur > 16'h1000 || cur !== 16'(m1.inc)) begin
            fails++; $display("FAIL glide_rise: inc=%h prev=%h, want %h", cur, pi, 16'(m1.inc));
         end
         pi = cur;
      end
      tests++;
      if (u_d1.inc !== 16'h1000) begin
         fails++; $display("FAIL glide_reach: inc=%h, want 1000", u_d1.inc);
      end
      tune1 = 16'h0FFF; tv1 = 1;
      cyc();
      tv1 = 0;
      cyc();
      tests++;
      if (u_d1.inc !== 16'h1000) begin
         fails++; $display("FAIL glide_hold: inc=%h, want 1000", u_d1.inc);
      end
      cyc();
      tests++;
      if (u_d1.inc !== 16'h0FFF) begin
         fails++; $display("FAIL glide_down1: inc=%h, want 0fff", u_d1.inc);
      end
   endtask
`endif

   function automatic logic [15:0] rnd_tune();
      case ($urandom_range(0, 7))
         0:       return 16'h0000;
         1:       return 16'hFFFF;
         default: return 16'($urandom);
      endcase
   endfunction

   task automatic test_random();
      do_reset();
      for (int i = 0; i < 3000 && fails < 20; i++) begin
         en1 = $urandom_range(0, 7) != 0;
         en4 = $urandom_range(0, 7) != 0;
         sync1 = $urandom_range(0, 63) == 0;
         sync4 = $urandom_range(0, 63) == 0;
         if (!(tv1 && !rdy1)) begin tv1 = $urandom_range(0, 3) == 0; tune1 = rnd_tune(); end
         if (!(tv4 && !rdy4)) begin tv4 = $urandom_range(0, 3) == 0; tune4 = rnd_tune(); end
         cyc();
         tests++;
         if ({phase1, wrap1, tick1, rdy1} !== {14'(m1.acc >> 10), m1.wrap, m1.tick, !m1.pend}) begin
            fails++;
            $display("FAIL rand_d1 cyc %0d: phase=%h wrap=%b tick=%b ready=%b, want %h %b %b %b",
                     i, phase1, wrap1, tick1, rdy1, 14'(m1.acc >> 10), m1.wrap, m1.tick, !m1.pend);
         end
         tests++;
         if ({phase4, wrap4, tick4, rdy4} !== {14'(m4.acc >> 10), m4.wrap, m4.tick, !m4.pend}) begin
            fails++;
            $display("FAIL rand_d4 cyc %0d: phase=%h wrap=%b tick=%b ready=%b, want %h %b %b %b",
                     i, phase4, wrap4, tick4, rdy4, 14'(m4.acc >> 10), m4.wrap, m4.tick, !m4.pend);
         end
      end
      tv1 = 0; tv4 = 0;
   endtask

   initial begin
      rst = 1'b1;
      en1 = 0; sync1 = 0; tv1 = 0; tune1 = '0;
      en4 = 0; sync4 = 0; tv4 = 0; tune4 = '0;
      m1 = '{default: 0};
      m4 = '{default: 0};
      test_reset();
`ifdef DDS_GLIDE_EN
      test_glide();
`else
      test_tune_step();
      test_div4();
      test_sync();
      test_en_gate();
`endif
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
